segmux_ctrl: RTL and testbench
==============================

// Module: segmux_ctrl
// PURPOSE
//  Wishbone-slave controller for a time-multiplexed bank of 1..16 seven-segment
//  digits with shared segment lines and per-digit anode selects. Adds brightness
//  PWM, per-digit blank, decimal point and blink, plus a raw-segment mode.
//  Sits on the peripheral bus; drives board display pins directly.
// PARAMETERS
//  DIGITS       8     number of digits, 1..16
//  SEG          7     segment lines per digit, 7..8
//  CLK_DIV      1000  clk_i cycles per PWM sub-slot tick, >=2
//  BLINK_FRAMES 64    full scan frames per blink half-period, >=1
//  ACTIVE_LOW   1     1: seg_o/dp_o/an_o asserted low; 0: asserted high
// PORTS
//  clk_i   in   1       clock
//  rst_i   in   1       reset, asynchronous, active-high
//  bus     slave if_wb  32-bit Wishbone: cyc,stb,we,adr,dat,ack,stall; sel ignored
//  seg_o   out  SEG     shared segment drive, bit0 = segment a
//  dp_o    out  1       shared decimal-point drive
//  an_o    out  DIGITS  digit select, at most one asserted
// BEHAVIOUR
//  Register map (word index = adr[6:2]); other indices read 0, writes dropped, still acked:
//   0 CTRL   rw [3:0] bright (reset 8), [4] enable (reset 0), [5] raw (reset 0)
//   1 STATUS ro [3:0] current digit index, [4] blink phase, [5] enable
//   16+i DIGIT[i] rw, i<DIGITS: [7:0] value, [8] dp, [9] blank, [10] blink; reset 0x200
//  Bus: 2-state FSM IDLE/ACK. IDLE & cyc & stb -> ACK; write or read captured that cycle.
//   ACK lasts exactly 1 cycle, dat_o valid while ack=1, then IDLE. stall = (state==ACK).
//   Latency: ack on cycle after accept. Unused dat bits read 0; writes take bits listed.
//  Scan: prescaler counts 0..CLK_DIV-1; tick on wrap. 4-bit pwm counter advances per tick.
//   pwm 15->0 wrap advances digit index; index DIGITS-1 -> 0 ends a frame.
//   Frame counter 0..BLINK_FRAMES-1; wrap toggles blink phase.
//  Digit lit iff enable & (pwm < bright) & ~blank & ~(blink & phase).
//   bright=0 -> dark; bright=15 -> 15/16 duty; pwm=15 always dark (anti-ghost gap).
//  Segments: raw=0 -> hexdisp(value[4:0]); raw=1 -> value[SEG-1:0] direct.
//  Outputs registered: reflect state one cycle after counters/regs change.
//  Unlit: an_o, seg_o, dp_o all at inactive level; dp_o asserted only if lit & dp.
//  enable=0: counters keep running, outputs inactive; STATUS still advances.
//  DIGIT write takes effect on next output update; no tearing of a lit slot needed.
//  Reset (any time, async): FSM IDLE, ack=0, counters 0, phase 0, regs to reset values,
//   all outputs inactive (ACTIVE_LOW=1 -> all ones) immediately.
// TESTING
//  Reset, read CTRL -> 0x08; read DIGIT[0] (adr 0x40) -> 0x200; an_o all 1s.
//  Write CTRL=0x1F, DIGIT[2]=0x005 -> when STATUS idx=2 and pwm<15, an_o=~(1<<2),
//   seg_o=~hexdisp(5), dp_o=1; other slots dark.
//  CTRL bright=4, CLK_DIV=4 -> each digit lit exactly 16 clk of 64, then dark 48.
//  DIGIT[1]=0x405, BLINK_FRAMES=1 -> digit 1 lit in even frames, dark in odd.
//  CTRL=0x3F, DIGIT[0]=0x17F -> seg_o=7'h00 (all on), dp_o=0 in digit-0 slot.
//  Back-to-back stb: ack 1 cycle after each accept, stall=1 in ACK; rst_i mid-ACK -> ack=0.

Source files
------------

// File: rtl/segmux_ctrl.sv
// segmux_ctrl: Wishbone-controlled time-multiplexed seven-segment driver with
// PWM brightness, per-digit blank/dp/blink and a raw-segment mode.
module segmux_ctrl #(
   parameter int unsigned DIGITS       = 8,
   parameter int unsigned SEG          = 7,
   parameter int unsigned CLK_DIV      = 1000,
   parameter int unsigned BLINK_FRAMES = 64,
   parameter bit          ACTIVE_LOW   = 1'b1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              wb_cyc_i,
   input  logic              wb_stb_i,
   input  logic              wb_we_i,
   input  logic [31:0]       wb_adr_i,
   input  logic [31:0]       wb_dat_i,
   input  logic [3:0]        wb_sel_i,
   output logic [31:0]       wb_dat_o,
   output logic              wb_ack_o,
   output logic              wb_stall_o,
   output logic [SEG-1:0]    seg_o,
   output logic              dp_o,
   output logic [DIGITS-1:0] an_o
);

   localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int unsigned PRE_W = $clog2(CLK_DIV);
   localparam int unsigned FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);
   localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

   typedef enum logic {IDLE, ACK} bus_state_e;

   bus_state_e        state_q;
   logic [31:0]       dat_q;
   logic [3:0]        bright_q;
   logic              enable_q;
   logic              raw_q;
   logic [7:0]        dig_val_q [DIGITS];
   logic [DIGITS-1:0] dig_dp_q;
   logic [DIGITS-1:0] dig_blank_q;
   logic [DIGITS-1:0] dig_blink_q;

   logic [PRE_W-1:0]  presc_q, presc_d;
   logic [3:0]        pwm_q, pwm_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [FRM_W-1:0]  frm_q, frm_d;
   logic              phase_q, phase_d;

   logic [DIGITS-1:0] an_q;
   logic [SEG-1:0]    seg_q;
   logic              dpo_q;

   logic [4:0]        word;
   logic              accept;
   logic [31:0]       rdata;
   logic [7:0]        cur_val;
   logic              cur_dp, cur_blank, cur_blink;
   logic              lit_c;
   logic [SEG-1:0]    seg_act;
   logic [DIGITS-1:0] an_act;
   logic              unused_bits;

   // Digit value to gfedcba pattern; codes 16..31 show nothing.
   function automatic logic [7:0] hexdisp(input logic [4:0] v);
      logic [7:0] s;
      case (v)
         5'h00: s = 8'h3F;  5'h01: s = 8'h06;  5'h02: s = 8'h5B;  5'h03: s = 8'h4F;
         5'h04: s = 8'h66;  5'h05: s = 8'h6D;  5'h06: s = 8'h7D;  5'h07: s = 8'h07;
         5'h08: s = 8'h7F;  5'h09: s = 8'h6F;  5'h0A: s = 8'h77;  5'h0B: s = 8'h7C;
         5'h0C: s = 8'h39;  5'h0D: s = 8'h5E;  5'h0E: s = 8'h79;  5'h0F: s = 8'h71;
         default: s = 8'h00;
      endcase
      return s;
   endfunction

   assign word        = wb_adr_i[6:2];
   assign accept      = (state_q == IDLE) && wb_cyc_i && wb_stb_i;
   assign wb_ack_o    = (state_q == ACK);
   assign wb_stall_o  = (state_q == ACK);
   assign wb_dat_o    = dat_q;
   assign an_o        = an_q;
   assign seg_o       = seg_q;
   assign dp_o        = dpo_q;
   assign unused_bits = ^{wb_adr_i[31:7], wb_adr_i[1:0], wb_dat_i[31:11], wb_sel_i, cur_val};

   // Register read mux
   always_comb begin
      rdata = '0;
      if (word == 5'd0) begin
         rdata = 32'({raw_q, enable_q, bright_q});
      end else if (word == 5'd1) begin
         rdata = 32'({enable_q, phase_q, 4'(idx_q)});
      end else if (word[4]) begin
         for (int i = 0; i < DIGITS; i++) begin
            if (word[3:0] == 4'(i)) begin
               rdata = 32'({dig_blink_q[i], dig_blank_q[i], dig_dp_q[i], dig_val_q[i]});
            end
         end
      end
   end

   // Bus FSM and register file
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         dat_q       <= '0;
         bright_q    <= 4'd8;
         enable_q    <= 1'b0;
         raw_q       <= 1'b0;
         dig_dp_q    <= '0;
         dig_blank_q <= '1;
         dig_blink_q <= '0;
         for (int i = 0; i < DIGITS; i++) begin
            dig_val_q[i] <= '0;
         end
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  state_q <= ACK;
                  dat_q   <= wb_we_i ? 32'd0 : rdata;
                  if (wb_we_i && (word == 5'd0)) begin
                     bright_q <= wb_dat_i[3:0];
                     enable_q <= wb_dat_i[4];
                     raw_q    <= wb_dat_i[5];
                  end
                  for (int i = 0; i < DIGITS; i++) begin
                     if (wb_we_i && (word == 5'(16 + i))) begin
                        dig_val_q[i]   <= wb_dat_i[7:0];
                        dig_dp_q[i]    <= wb_dat_i[8];
                        dig_blank_q[i] <= wb_dat_i[9];
                        dig_blink_q[i] <= wb_dat_i[10];
                     end
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Prescaler -> pwm -> digit index -> frame -> blink phase chain
   always_comb begin
      presc_d = presc_q + PRE_W'(1);
      pwm_d   = pwm_q;
      idx_d   = idx_q;
      frm_d   = frm_q;
      phase_d = phase_q;
      if (presc_q == PRE_LAST) begin
         presc_d = '0;
         pwm_d   = pwm_q + 4'd1;
         if (pwm_q == 4'hF) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
            if (idx_q == IDX_LAST) begin
               frm_d = (frm_q == FRM_LAST) ? '0 : frm_q + FRM_W'(1);
               if (frm_q == FRM_LAST) begin
                  phase_d = ~phase_q;
               end
            end
         end
      end
   end

   always_comb begin
      cur_val   = '0;
      cur_dp    = 1'b0;
      cur_blank = 1'b0;
      cur_blink = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx_q == IDX_W'(i)) begin
            cur_val   = dig_val_q[i];
            cur_dp    = dig_dp_q[i];
            cur_blank = dig_blank_q[i];
            cur_blink = dig_blink_q[i];
         end
      end
   end

   // pwm==15 can never be below a 4-bit bright, leaving a dark gap between digits
   assign lit_c   = enable_q && (pwm_q < bright_q) && !cur_blank && !(cur_blink && phase_q);
   assign seg_act = raw_q ? cur_val[SEG-1:0] : SEG'(hexdisp(cur_val[4:0]));
   assign an_act  = lit_c ? (DIGITS'(1) << idx_q) : '0;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         presc_q <= '0;
         pwm_q   <= '0;
         idx_q   <= '0;
         frm_q   <= '0;
         phase_q <= 1'b0;
         an_q    <= {DIGITS{ACTIVE_LOW}};
         seg_q   <= {SEG{ACTIVE_LOW}};
         dpo_q   <= ACTIVE_LOW;
      end else begin
         presc_q <= presc_d;
         pwm_q   <= pwm_d;
         idx_q   <= idx_d;
         frm_q   <= frm_d;
         phase_q <= phase_d;
         an_q    <= an_act ^ {DIGITS{ACTIVE_LOW}};
         seg_q   <= (lit_c ? seg_act : '0) ^ {SEG{ACTIVE_LOW}};
         dpo_q   <= (lit_c && cur_dp) ^ ACTIVE_LOW;
      end
   end

endmodule

// File: tb/tb_segmux_ctrl.sv
// tb_segmux_ctrl: randomized bench for segmux_ctrl against a time-based
// reference model of the scan (position derived from cycles since reset).
module tb_segmux_ctrl;

   localparam int D    = 4;
   localparam int SEG  = 7;
   localparam int CD   = 4;
   localparam int BF   = 1;
   localparam int SLOT = CD * 16;

   logic           clk_i = 1'b0;
   logic           rst_i = 1'b1;
   logic           wb_cyc_i = 1'b0;
   logic           wb_stb_i = 1'b0;
   logic           wb_we_i = 1'b0;
   logic [31:0]    wb_adr_i = '0;
   logic [31:0]    wb_dat_i = '0;
   logic [3:0]     wb_sel_i = 4'hF;
   logic [31:0]    wb_dat_o;
   logic           wb_ack_o;
   logic           wb_stall_o;
   logic [SEG-1:0] seg_o;
   logic           dp_o;
   logic [D-1:0]   an_o;

   segmux_ctrl #(
      .DIGITS(D), .SEG(SEG), .CLK_DIV(CD), .BLINK_FRAMES(BF), .ACTIVE_LOW(1'b1)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
      .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
      .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_stall_o(wb_stall_o),
      .seg_o(seg_o), .dp_o(dp_o), .an_o(an_o)
   );

   always #5 clk_i = ~clk_i;

   // Clock edges seen since reset was released
   int edge_n;
   always @(posedge clk_i) begin
      if (rst_i) edge_n <= 0;
      else       edge_n <= edge_n + 1;
   end

   int n_chk  = 0;
   int n_pass = 0;
   int lit_cnt [D];

   logic [6:0]  hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
   logic [31:0] m_ctrl;
   logic [31:0] m_dig [D];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
   endtask

   task automatic model_reset();
      m_ctrl = 32'h08;
      for (int i = 0; i < D; i++) m_dig[i] = 32'h200;
   endtask

   // Expected {an, seg, dp} seen after n clock edges (outputs lag counters by one edge)
   function automatic logic [11:0] exp_disp(input int n);
      int t, pwm, idx, phase;
      logic [31:0] d;
      logic [6:0]  seg;
      logic [3:0]  an;
      logic        lit;
      if (n <= 0) return 12'hFFF;
      t     = n - 1;
      pwm   = (t / CD) % 16;
      idx   = (t / SLOT) % D;
      phase = ((t / (SLOT * D)) / BF) % 2;
      d     = m_dig[idx];
      lit   = m_ctrl[4] && (pwm < int'(m_ctrl[3:0])) && !d[9] && !(d[10] && phase == 1);
      if (!lit) return 12'hFFF;
      an = ~(4'b0001 << idx);
      if (m_ctrl[5])  seg = d[6:0];
      else if (d[4])  seg = 7'h00;
      else            seg = hex_tab[d[3:0]];
      return {an, ~seg, ~d[8]};
   endfunction

   function automatic logic [31:0] exp_read(input logic [31:0] adr, input int m);
      int w, idx, phase;
      w = int'(adr[6:2]);
      if (w == 0) return m_ctrl;
      if (w == 1) begin
         idx   = (m / SLOT) % D;
         phase = ((m / (SLOT * D)) / BF) % 2;
         return (32'(m_ctrl[4]) << 5) | (32'(phase) << 4) | 32'(idx);
      end
      if (w >= 16 && w < 16 + D) return m_dig[w - 16];
      return 32'h0;
   endfunction

   // One single-beat transfer; t_acc is the edge count just before the accepting edge
   task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                          output logic [31:0] rdat, output int t_acc);
      @(negedge clk_i);
      check("stall_idle", 32'(wb_stall_o), 32'd0);
      t_acc    = edge_n;
      wb_cyc_i = 1'b1;
      wb_stb_i = 1'b1;
      wb_we_i  = we;
      wb_adr_i = adr;
      wb_dat_i = wdat;
      @(posedge clk_i); #1;
      check("ack", 32'(wb_ack_o), 32'd1);
      check("stall_ack", 32'(wb_stall_o), 32'd1);
      rdat     = wb_dat_o;
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
      wb_we_i  = 1'b0;
      @(posedge clk_i); #1;
      check("ack_drop", 32'(wb_ack_o), 32'd0);
   endtask

   task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat);
      logic [31:0] r;
      int t, w;
      wb_xfer(1'b1, adr, dat, r, t);
      w = int'(adr[6:2]);
      if (w == 0) m_ctrl = dat & 32'h3F;
      else if (w >= 16 && w < 16 + D) m_dig[w - 16] = dat & 32'h7FF;
   endtask

   task automatic wb_read_chk(input string tag, input logic [31:0] adr);
      logic [31:0] r;
      int t;
      wb_xfer(1'b0, adr, 32'h0, r, t);
      check(tag, r, exp_read(adr, t));
   endtask

   // Compare every cycle to the model and tally lit cycles per digit
   task automatic scan_check(input int n);
      for (int i = 0; i < D; i++) lit_cnt[i] = 0;
      @(negedge clk_i);
      for (int k = 0; k < n; k++) begin
         @(negedge clk_i);
         check("disp", 32'({an_o, seg_o, dp_o}), 32'(exp_disp(edge_n)));
         for (int i = 0; i < D; i++) if (an_o[i] == 1'b0) lit_cnt[i]++;
      end
   endtask

   task automatic wait_an(input string tag, input logic [D-1:0] target);
      logic found;
      found = 1'b0;
      @(negedge clk_i);
      for (int k = 0; k < 600 && !found; k++) begin
         @(negedge clk_i);
         if (an_o == target) found = 1'b1;
      end
      check(tag, 32'(found), 32'd1);
   endtask

   logic [31:0] rc, rd;

   initial begin
      model_reset();
      repeat (3) @(negedge clk_i);
      check("rst_disp", 32'({an_o, seg_o, dp_o}), 32'hFFF);
      check("rst_ack", 32'(wb_ack_o), 32'd0);
      check("rst_stall", 32'(wb_stall_o), 32'd0);
      rst_i = 1'b0;

      wb_read_chk("ctrl_rst", 32'h00);
      check("ctrl_rst_val", m_ctrl, 32'h08);
      wb_read_chk("dig0_rst", 32'h40);
      wb_read_chk("dig3_rst", 32'h4C);
      wb_read_chk("status", 32'h04);

      // Hex digit 5 on digit 2 at full brightness
      wb_write(32'h00, 32'h1F);
      wb_write(32'h48, 32'h005);
      wait_an("wait_dig2", 4'b1011);
      check("dig2_seg", 32'(seg_o), 32'h12);
      check("dig2_dp", 32'(dp_o), 32'd1);
      scan_check(256);
      check("dig2_lit", 32'(lit_cnt[2]), 32'd60);
      check("dig0_dark", 32'(lit_cnt[0]), 32'd0);

      // Brightness 4: 16 lit clocks per 64-clock slot
      wb_write(32'h00, 32'h14);
      for (int i = 0; i < D; i++) wb_write(32'h40 + 32'(4 * i), 32'h000);
      scan_check(256);
      for (int i = 0; i < D; i++) check("bright4_cnt", 32'(lit_cnt[i]), 32'd16);

      // Blinking digit 1: lit one frame, dark the next
      wb_write(32'h00, 32'h1F);
      for (int i = 0; i < D; i++) wb_write(32'h40 + 32'(4 * i), (i == 1) ? 32'h405 : 32'h200);
      scan_check(512);
      check("blink_cnt", 32'(lit_cnt[1]), 32'd60);
      check("blink_other", 32'(lit_cnt[3]), 32'd0);

      // Raw mode, all segments and dp on digit 0
      wb_write(32'h00, 32'h3F);
      wb_write(32'h40, 32'h17F);
      wait_an("wait_dig0", 4'b1110);
      check("raw_seg", 32'(seg_o), 32'h00);
      check("raw_dp", 32'(dp_o), 32'd0);
      scan_check(256);

      // Disabled: dark outputs, counters keep running
      wb_write(32'h00, 32'h0F);
      wb_read_chk("status_off0", 32'h04);
      scan_check(128);
      check("off_dark", 32'(lit_cnt[0] + lit_cnt[1] + lit_cnt[2] + lit_cnt[3]), 32'd0);
      wb_read_chk("status_off1", 32'h04);

      // Unmapped and out-of-range indices
      wb_write(32'h08, 32'hFFFF_FFFF);
      wb_write(32'h50, 32'hFFFF_FFFF);
      wb_read_chk("unmapped", 32'h08);
      wb_read_chk("dig_oor", 32'h50);
      wb_read_chk("ctrl_keep", 32'h00);

      // Back-to-back strobes: accept, ack, accept, ack ...
      @(negedge clk_i);
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 32'h00;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk_i); #1;
         check("b2b_ack", 32'(wb_ack_o), (k % 2 == 0) ? 32'd1 : 32'd0);
         check("b2b_stall", 32'(wb_stall_o), (k % 2 == 0) ? 32'd1 : 32'd0);
         if (k % 2 == 0) check("b2b_dat", wb_dat_o, m_ctrl);
      end
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0;

      // Reset during the ACK cycle
      wb_write(32'h00, 32'h1F);
      wb_write(32'h40, 32'h008);
      wait_an("wait_pre_rst", 4'b1110);
      @(negedge clk_i);
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_adr_i = 32'h00;
      @(posedge clk_i); #1;
      check("mid_ack", 32'(wb_ack_o), 32'd1);
      rst_i = 1'b1;
      #1;
      check("rst_ack_clr", 32'(wb_ack_o), 32'd0);
      check("rst_stall_clr", 32'(wb_stall_o), 32'd0);
      check("rst_disp_clr", 32'({an_o, seg_o, dp_o}), 32'hFFF);
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
      model_reset();
      repeat (2) @(negedge clk_i);
      rst_i = 1'b0;
      wb_read_chk("ctrl_rst2", 32'h00);
      wb_read_chk("dig0_rst2", 32'h40);

      // Randomized configurations
      for (int r = 0; r < 8; r++) begin
         for (int i = 0; i < D; i++) begin
            rd = $urandom & 32'h7FF;
            if ($urandom_range(3) != 0) rd[9] = 1'b0;
            wb_write(32'h40 + 32'(4 * i), rd);
         end
         rc = {26'b0, ($urandom_range(2) == 0), ($urandom_range(3) != 0), 4'($urandom)};
         wb_write(32'h00, rc);
         scan_check(320);
         wb_read_chk("rand_rd", {25'b0, 5'($urandom), 2'b00});
         wb_read_chk("rand_status", 32'h04);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
